// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: two read ports, special-register readout,
// two general write ports and the dedicated special-register write port.
interface reg_file_mp_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic [DATA_W-1:0] spec_data;
    logic              wr_en1;
    logic [ADDR_W-1:0] wr_addr1;
    logic [DATA_W-1:0] wr_data1;
    logic              wr_en2;
    logic [ADDR_W-1:0] wr_addr2;
    logic [DATA_W-1:0] wr_data2;
    logic              spec_wr_en;
    logic [DATA_W-1:0] spec_wr_data;

    modport master (
        output rd_addr1, rd_addr2, wr_en1, wr_addr1, wr_data1,
               wr_en2, wr_addr2, wr_data2, spec_wr_en, spec_wr_data,
        input  rd_data1, rd_data2, spec_data
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en1, wr_addr1, wr_data1,
               wr_en2, wr_addr2, wr_data2, spec_wr_en, spec_wr_data,
        output rd_data1, rd_data2, spec_data
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file with prioritised writes (spec > port2 > port1), optional
// write-first bypass, optional registered reads and optional hardwired-zero R0.
module reg_file_mp #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int SPEC_IDX = 15,
    parameter int ZERO_R0  = 0,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input logic          clk,
    input logic          rst,
    reg_file_mp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] SPEC_ADDR = SPEC_IDX[ADDR_W-1:0];

    logic [DATA_W-1:0] r_regs [DEPTH];

    logic              w_we1;
    logic              w_we2;
    logic              w_weSpec;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [DATA_W-1:0] w_spec;

    // Reset suppresses writes, and R0 swallows writes when it is hardwired to zero.
    assign w_we1    = bus.wr_en1 && !rst && !(ZERO_R0 != 0 && bus.wr_addr1 == '0);
    assign w_we2    = bus.wr_en2 && !rst && !(ZERO_R0 != 0 && bus.wr_addr2 == '0);
    assign w_weSpec = bus.spec_wr_en && !rst && !(ZERO_R0 != 0 && SPEC_ADDR == '0);

    function automatic logic [DATA_W-1:0] resolveRead(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              we1,
        input logic [ADDR_W-1:0] wa1,
        input logic [DATA_W-1:0] wd1,
        input logic              we2,
        input logic [ADDR_W-1:0] wa2,
        input logic [DATA_W-1:0] wd2,
        input logic              weSpec,
        input logic [DATA_W-1:0] wdSpec
    );
        logic [DATA_W-1:0] value;
        value = stored;
        if (BYPASS != 0) begin
            if (we1 && wa1 == addr)          value = wd1;
            if (we2 && wa2 == addr)          value = wd2;
            if (weSpec && SPEC_ADDR == addr) value = wdSpec;
        end
        if (ZERO_R0 != 0 && addr == '0) value = '0;
        return value;
    endfunction

    always_comb begin
        w_rd1  = resolveRead(bus.rd_addr1, r_regs[bus.rd_addr1], w_we1, bus.wr_addr1, bus.wr_data1,
                             w_we2, bus.wr_addr2, bus.wr_data2, w_weSpec, bus.spec_wr_data);
        w_rd2  = resolveRead(bus.rd_addr2, r_regs[bus.rd_addr2], w_we1, bus.wr_addr1, bus.wr_data1,
                             w_we2, bus.wr_addr2, bus.wr_data2, w_weSpec, bus.spec_wr_data);
        w_spec = resolveRead(SPEC_ADDR, r_regs[SPEC_ADDR], w_we1, bus.wr_addr1, bus.wr_data1,
                             w_we2, bus.wr_addr2, bus.wr_data2, w_weSpec, bus.spec_wr_data);
    end

    // Later non-blocking assignments win, so the order below encodes the write priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else begin
            if (w_we1)    r_regs[bus.wr_addr1] <= bus.wr_data1;
            if (w_we2)    r_regs[bus.wr_addr2] <= bus.wr_data2;
            if (w_weSpec) r_regs[SPEC_ADDR]    <= bus.spec_wr_data;
        end
    end

    generate
        if (READ_REG != 0) begin : gRegOut
            logic [DATA_W-1:0] r_rd1;
            logic [DATA_W-1:0] r_rd2;
            logic [DATA_W-1:0] r_spec;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd1  <= '0;
                    r_rd2  <= '0;
                    r_spec <= '0;
                end else begin
                    r_rd1  <= w_rd1;
                    r_rd2  <= w_rd2;
                    r_spec <= w_spec;
                end
            end

            assign bus.rd_data1  = r_rd1;
            assign bus.rd_data2  = r_rd2;
            assign bus.spec_data = r_spec;
        end else begin : gCombOut
            assign bus.rd_data1  = w_rd1;
            assign bus.rd_data2  = w_rd2;
            assign bus.spec_data = w_spec;
        end
    endgenerate

    always_ff @(posedge clk) begin
        assert (SPEC_IDX < DEPTH)
        else $error("reg_file_mp: SPEC_IDX (%0d) must be below DEPTH (%0d)", SPEC_IDX, DEPTH);
    end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the datapath: two general read ports, one dedicated read port for a special register, two general write ports, and one dedicated special-register write port.
- The special register (default R15) holds the high half of multiply results and the remainder from divide.
- Adds over the previous fixed 16x16 file:
  - sequential writes with a deterministic conflict priority;
  - optional same-cycle write-to-read bypass;
  - optional registered read outputs;
  - optional hardwired-zero R0.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers.
- SPEC_IDX, 15, index of the special register served by spec_data / spec_wr_*. Must be < DEPTH.
- ZERO_R0, 0, when 1, R0 always reads 0 and writes to it are discarded.
- BYPASS, 1, when 1, reads return data being written in the same cycle (write-first).
- READ_REG, 0, 0 = combinational read outputs; 1 = outputs registered, 1-cycle latency.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data1  out  DATA_W  read port 1 data.
- rd_data2  out  DATA_W  read port 2 data.
- spec_data  out  DATA_W  contents of register SPEC_IDX.
- wr_en1  in  1  write enable, port 1.
- wr_addr1  in  ADDR_W  write address, port 1.
- wr_data1  in  DATA_W  write data, port 1.
- wr_en2  in  1  write enable, port 2.
- wr_addr2  in  ADDR_W  write address, port 2.
- wr_data2  in  DATA_W  write data, port 2.
- spec_wr_en  in  1  write enable for register SPEC_IDX.
- spec_wr_data  in  DATA_W  data for register SPEC_IDX.

Behaviour:
- Reset: rst=1 at a rising edge clears all DEPTH registers to 0. When READ_REG=1, the registered rd_data1/rd_data2/spec_data also clear to 0. rst overrides every write enable in that cycle.
- Writes take effect at the rising edge; stored values are visible in the array from the next cycle.
- Write priority, when more than one write targets the same register in one cycle: spec_wr_en > wr_en2 > wr_en1. The highest-priority data is stored; the others are dropped for that register.
- Writes to different registers in the same cycle all complete.
- ZERO_R0=1:
  - writes to address 0 are ignored, even if they are the highest-priority write;
  - reads of address 0 return 0, including under bypass;
  - if SPEC_IDX=0 with ZERO_R0=1, spec writes are ignored.
- Read value with READ_REG=0:
  - combinational: rd_dataN = reg[rd_addrN];
  - with BYPASS=1, if a write to rd_addrN is enabled this cycle, rd_dataN = the winning write data for that address, per the priority rule.
- spec_data follows the same rules with address fixed to SPEC_IDX.
- READ_REG=1: the value above is computed from the current-cycle addresses/writes and registered, so it appears 1 cycle later.
- BYPASS=0: reads return pre-write contents in the write cycle; new data appears from the next cycle (READ_REG=0) or the cycle after that (READ_REG=1).
- Out-of-range parameters (SPEC_IDX >= DEPTH) are a configuration error; flag with a simulation-time check.
- No X propagation: every register is reset, and reads of any address are always defined.

Test Plan:
- Reset: write 0xABCD to all 16 registers, assert rst for 1 cycle -> every read of addresses 0..15 returns 0x0000; spec_data=0x0000.
- Basic write/read (BYPASS=0, READ_REG=0): wr_en1, addr 3, 0x1234 at edge N -> rd_data1 with rd_addr1=3 reads 0x1234 after edge N; reads old value 0x0000 before edge N.
- Triple conflict on SPEC_IDX=15: wr1=0x1111, wr2=0x2222, spec=0x3333 all targeting 15 in one cycle -> spec_data and reg 15 = 0x3333. Then wr1=0x1111 and wr2=0x2222 both to addr 7 -> reg 7 = 0x2222.
- Bypass (BYPASS=1, READ_REG=0): rd_addr2=5 while wr_en2 writes 0x00FF to 5 -> rd_data2=0x00FF in the same cycle, before the edge.
- Registered read (READ_REG=1): reg 9 = 0x5A5A, set rd_addr1=9 at edge N -> rd_data1=0x5A5A only after edge N+1's output register update (1-cycle latency). rst mid-stream -> rd_data1=0 on the next edge.
- ZERO_R0=1: wr_en1 writes 0xBEEF to addr 0, including with bypass enabled -> rd_data1 at addr 0 returns 0x0000 in the same cycle and all later cycles.
